// File: rtl/dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dino_motion_ctrl
// Runner-character FSM (stop/run/duck/jump/die) with fixed-point jump physics.
// Optional feature macro: DINO_DOUBLE_JUMP_EN (one mid-air re-launch per jump).
// Revision : 1.0
// ============================================================================
module dino_motion_ctrl #(
    parameter int X_POS       = 20,
    parameter int Y_W         = 9,
    parameter int GROUND_Y    = 400,
    parameter int DUCK_DY     = 17,
    parameter int FRAC_BITS   = 1,
    parameter int V0          = 10,
    parameter int G           = 1,
    parameter int G_FAST      = 3,
    parameter int V_CUT       = 3,
    parameter int ANIM_W      = 8,
    parameter int ANIM_BIT    = 3,
    parameter int SPARKLE_BIT = 7
) (
    input  logic           clk_25MHz,
    input  logic           rst,
    input  logic           phys_tick,
    input  logic           anim_tick,
    input  logic           start,
    input  logic           restart,
    input  logic           up,
    input  logic           down,
    input  logic           kill,
    output logic [9:0]     x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     state,
    output logic           anim_frame,
    output logic           sparkle,
    output logic           airborne,
    output logic           landed
);

    localparam int HW = Y_W + FRAC_BITS + 2;

    localparam logic signed [HW-1:0] V0_S       = HW'(V0);
    localparam logic signed [HW-1:0] G_S        = HW'(G);
    localparam logic signed [HW-1:0] G_FAST_S   = HW'(G_FAST);
    localparam logic signed [HW-1:0] V_CUT_S    = HW'(V_CUT);
    localparam logic signed [HW-1:0] H_MAX      = HW'(GROUND_Y << FRAC_BITS);
    localparam logic signed [HW:0]   H_MAX_X    = (HW+1)'(GROUND_Y << FRAC_BITS);
    localparam logic signed [HW-1:0] Y_GROUND_H = HW'(GROUND_Y);
    localparam logic [Y_W-1:0]       Y_GROUND   = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0]       Y_DUCK     = Y_W'(GROUND_Y + DUCK_DY);

    typedef enum logic [2:0] {
        ST_STOP = 3'b000,
        ST_RUN  = 3'b001,
        ST_DUCK = 3'b010,
        ST_JUMP = 3'b011,
        ST_DIE  = 3'b110
    } state_t;

    state_t                 st, nx_state;
    logic signed [HW-1:0]   h, v, nx_h, nx_v, v_c, h_sat;
    logic signed [HW:0]     h_sum;
    logic [Y_W-1:0]         nx_y;
    logic [ANIM_W-1:0]      cnt, nx_cnt;
    logic                   armed, nx_armed, nx_landed;
`ifdef DINO_DOUBLE_JUMP_EN
    logic                   dbl, nx_dbl;
`endif

    always_comb begin
        nx_state  = st;
        nx_h      = h;
        nx_v      = v;
        nx_y      = y;
        nx_cnt    = cnt;
        nx_landed = 1'b0;
        nx_armed  = armed | ~up;
`ifdef DINO_DOUBLE_JUMP_EN
        nx_dbl    = dbl;
`endif
        // Physics step terms: early-release clamp, then integrate with saturation.
        v_c   = (!up && (v > V_CUT_S)) ? V_CUT_S : v;
        h_sum = {h[HW-1], h} + {v_c[HW-1], v_c};
        h_sat = (h_sum > H_MAX_X) ? H_MAX : h_sum[HW-1:0];

        if (restart && (st != ST_STOP)) begin
            nx_state = ST_RUN;
            nx_h     = '0;
            nx_v     = '0;
            nx_y     = Y_GROUND;
`ifdef DINO_DOUBLE_JUMP_EN
            nx_dbl   = 1'b0;
`endif
        end else if (kill && (st inside {ST_RUN, ST_DUCK, ST_JUMP})) begin
            nx_state = ST_DIE;
            nx_cnt   = '0;
        end else begin
            case (st)
                ST_STOP: begin
                    if (anim_tick) nx_cnt = cnt + ANIM_W'(1);
                    if (start)     nx_state = ST_RUN;
                end
                ST_RUN: begin
                    if (anim_tick) nx_cnt = cnt + ANIM_W'(1);
                    if (up && !down && armed) begin
                        nx_state = ST_JUMP;
                        nx_h     = '0;
                        nx_v     = V0_S;
                        nx_armed = 1'b0;
                    end else if (down && !up) begin
                        nx_state = ST_DUCK;
                        nx_y     = Y_DUCK;
                    end
                end
                ST_DUCK: begin
                    if (anim_tick) nx_cnt = cnt + ANIM_W'(1);
                    if (!down) begin
                        nx_state = ST_RUN;
                        nx_y     = Y_GROUND;
                    end
                end
                ST_JUMP: begin
`ifdef DINO_DOUBLE_JUMP_EN
                    if (up && armed && !dbl) begin
                        nx_v     = V0_S;
                        nx_armed = 1'b0;
                        nx_dbl   = 1'b1;
                    end else
`endif
                    if (phys_tick) begin
                        if ((v_c < 0) && (h_sum <= 0)) begin
                            nx_h      = '0;
                            nx_v      = '0;
                            nx_landed = 1'b1;
                            nx_state  = down ? ST_DUCK : ST_RUN;
                            nx_y      = down ? Y_DUCK : Y_GROUND;
`ifdef DINO_DOUBLE_JUMP_EN
                            nx_dbl    = 1'b0;
`endif
                        end else begin
                            nx_h = h_sat;
                            nx_v = v_c - (down ? G_FAST_S : G_S);
                            nx_y = Y_W'(Y_GROUND_H - (h_sat >>> FRAC_BITS));
                        end
                    end
                end
                ST_DIE: ;
                default: nx_state = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            st       <= ST_STOP;
            h        <= '0;
            v        <= '0;
            y        <= Y_GROUND;
            cnt      <= '0;
            landed   <= 1'b0;
            armed    <= 1'b1;
            airborne <= 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
            dbl      <= 1'b0;
`endif
        end else begin
            st       <= nx_state;
            h        <= nx_h;
            v        <= nx_v;
            y        <= nx_y;
            cnt      <= nx_cnt;
            landed   <= nx_landed;
            armed    <= nx_armed;
            airborne <= (nx_state == ST_JUMP);
`ifdef DINO_DOUBLE_JUMP_EN
            dbl      <= nx_dbl;
`endif
        end
    end

    assign x          = 10'(X_POS);
    assign state      = st;
    assign anim_frame = cnt[ANIM_BIT];
    assign sparkle    = cnt[SPARKLE_BIT];

endmodule
`default_nettype wire
